// File: rtl/branch_pkg.sv
// Shared constants for the branch predictor: condition-select encodings,
// 2-bit saturating counter states and the counter update helper.
package branch_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_EQ   = 3'b001;
  localparam logic [2:0] BR_NE   = 3'b010;
  localparam logic [2:0] BR_LT   = 3'b011;
  localparam logic [2:0] BR_GE   = 3'b100;
  localparam logic [2:0] BR_LTU  = 3'b101;
  localparam logic [2:0] BR_GEU  = 3'b110;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } bht_state_e;

  // Saturating step toward the resolved direction.
  function automatic logic [1:0] bht_update(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != CNT_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != CNT_SNT) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decode from ALU flags.
module branch_cond
  import branch_pkg::*;
#(
  parameter int BRANCH_SRC_WIDTH = 3
) (
  input  logic [BRANCH_SRC_WIDTH-1:0] branch_src,
  input  logic                        zero,
  input  logic                        neg,
  input  logic                        negu,
  output logic                        branch
);

  always_comb begin
    branch = 1'b0;
    case (branch_src)
      BRANCH_SRC_WIDTH'(BR_EQ):  branch = zero;
      BRANCH_SRC_WIDTH'(BR_NE):  branch = ~zero;
      BRANCH_SRC_WIDTH'(BR_LT):  branch = neg;
      BRANCH_SRC_WIDTH'(BR_GE):  branch = ~neg | zero;
      BRANCH_SRC_WIDTH'(BR_LTU): branch = negu;
      BRANCH_SRC_WIDTH'(BR_GEU): branch = ~negu | zero;
      default:                   branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: 2-bit counter table, fetch lookup, execute update.
// Optional statistics counters are compiled in with BRANCH_STATS_EN.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int BRANCH_SRC_WIDTH = 3,
  parameter int PC_WIDTH         = 32,
  parameter int BHT_DEPTH        = 64,
  parameter int STATS_WIDTH      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PC_WIDTH-1:0]         pc_if,
  output logic                        pred_taken,
  input  logic                        valid_ex,
  input  logic [PC_WIDTH-1:0]         pc_ex,
  input  logic [BRANCH_SRC_WIDTH-1:0] branch_src,
  input  logic                        zero,
  input  logic                        neg,
  input  logic                        negu,
  input  logic                        pred_taken_ex,
  output logic                        branch,
  output logic                        mispredict,
  output logic                        mispredict_taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]      stat_branches,
  output logic [STATS_WIDTH-1:0]      stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht_reg [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             resolve;
  logic             miss;
  logic [1:0]       entry_next;
  logic             mispredict_reg;
  logic             mispredict_taken_reg;
  logic             unused_pc_bits;

  assign if_idx  = pc_if[IDX_W+1:2];
  assign ex_idx  = pc_ex[IDX_W+1:2];
  assign resolve = valid_ex && (branch_src != '0);
  assign miss    = branch != pred_taken_ex;

  assign unused_pc_bits = ^{pc_if[PC_WIDTH-1:IDX_W+2], pc_if[1:0],
                            pc_ex[PC_WIDTH-1:IDX_W+2], pc_ex[1:0]};

  branch_cond #(
    .BRANCH_SRC_WIDTH(BRANCH_SRC_WIDTH)
  ) u_cond (
    .branch_src(branch_src),
    .zero      (zero),
    .neg       (neg),
    .negu      (negu),
    .branch    (branch)
  );

  // Lookup reads the pre-edge table: a same-cycle update is not forwarded.
  assign pred_taken = bht_reg[if_idx][1];
  assign entry_next = bht_update(bht_reg[ex_idx], branch);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_reg[i] <= CNT_WNT;
      mispredict_reg       <= 1'b0;
      mispredict_taken_reg <= 1'b0;
    end else if (resolve) begin
      bht_reg[ex_idx]      <= entry_next;
      mispredict_reg       <= miss;
      mispredict_taken_reg <= branch;
    end else begin
      mispredict_reg       <= 1'b0;
    end
  end

  assign mispredict       = mispredict_reg;
  assign mispredict_taken = mispredict_taken_reg;

`ifdef BRANCH_STATS_EN
  logic [STATS_WIDTH-1:0] stat_branches_reg;
  logic [STATS_WIDTH-1:0] stat_mispredicts_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else if (resolve) begin
      if (stat_branches_reg != '1)
        stat_branches_reg <= stat_branches_reg + 1'b1;
      if (miss && (stat_mispredicts_reg != '1))
        stat_mispredicts_reg <= stat_mispredicts_reg + 1'b1;
    end
  end

  assign stat_branches    = stat_branches_reg;
  assign stat_mispredicts = stat_mispredicts_reg;
`else
  // Statistics counters are absent in this build.
`endif

endmodule
